relu_seq_ctrl: RTL and testbench
================================

# relu_seq_ctrl

Sequencer for the registered ReLU activation stage (`RELU`, `SUM_WIDTH`-bit, 1-cycle latency). On a start pulse it streams `len` words from an input buffer (synchronous-read RAM) through the ReLU stage and writes each result to the same address in an output buffer. It tracks the 2-stage read/ReLU pipeline and signals completion with a single-cycle `done`. It sits between the layer-level scheduler and the activation buffers.

## Interface
- `SUM_WIDTH`, 32, data word width (matches RELU)
- `NUM_DATA`, 128, buffer depth in words
- `ADDR_WIDTH`, `$clog2(NUM_DATA)`, buffer address width
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a pass; sampled only in IDLE
- `len`  in  ADDR_WIDTH+1  words to process; sampled with `start`
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse at end of pass
- `rd_en`  out  1  input buffer read strobe
- `rd_addr`  out  ADDR_WIDTH  input buffer address
- `rd_data`  in  SUM_WIDTH  input buffer data, valid 1 cycle after `rd_en`
- `relu_in`  out  SUM_WIDTH  to RELU `in_data` (combinational from `rd_data`)
- `relu_out`  in  SUM_WIDTH  from RELU `out_data` (1-cycle registered)
- `wr_en`  out  1  output buffer write strobe
- `wr_addr`  out  ADDR_WIDTH  output buffer address
- `wr_data`  out  SUM_WIDTH  output buffer data (= `relu_out`)
- `neg_count`  out  ADDR_WIDTH+1  clamped-input count (only with `RELU_SEQ_STATS_EN`)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: if `start`=1, latch `eff_len` = min(`len`, NUM_DATA).
  - If `eff_len`=0, go to DONE.
  - Otherwise go to RUN with rd counter = 0.
- RUN: `rd_en`=1, `rd_addr` = rd counter, increment each cycle. Move to DRAIN after issuing address `eff_len`-1.
- Pipeline tracking: 2-bit valid shift register `{v_relu, v_rd}`.
  - `v_rd` = registered `rd_en`; it marks `rd_data`/`relu_in` as valid.
  - `v_relu` = registered `v_rd`; it drives `wr_en`.
  - The write address counter starts at 0 and increments on each `wr_en`.
- DRAIN: `rd_en`=0. Go to DONE on the cycle the last write (`wr_addr` = `eff_len`-1) is issued.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; `len` changes mid-pass are ignored.
- `busy`=1 in RUN and DRAIN only.
- `relu_in` is driven from `rd_data` every cycle. Its value is meaningful only when `v_rd`=1.
- `wr_data` = `relu_out` unconditionally. The write is qualified by `wr_en`.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `rd_en`, `wr_en`=0; `rd_addr`, `wr_addr`=0; pipeline valids=0; `neg_count`=0.
- Reset asserted mid-pass aborts immediately. No further `rd_en`/`wr_en`, and no `done` pulse.
- Cycle-level sequence for `start` at cycle N with `eff_len`=L≥1:
  - `busy` is high on cycles N+1 … N+L+2.
  - `rd_en` is high on cycles N+1 … N+L, with `rd_addr` 0 … L-1.
  - `wr_en` is high on cycles N+3 … N+L+2, with `wr_addr` 0 … L-1.
  - `done` is high on cycle N+L+3.
  - Total start-to-done: L+3 cycles. Read-to-write latency: 2 cycles.
- `eff_len`=0: `done` at cycle N+1, `busy` never asserted, no buffer accesses.
- Earliest accepted back-to-back `start`: the cycle after `done`.
- Address counters never wrap. `eff_len` ≤ NUM_DATA guarantees the maximum address is NUM_DATA-1.

## Configuration
- Macro: `RELU_SEQ_STATS_EN`.
- Defined:
  - `neg_count` port exists.
  - It clears on accepted `start`.
  - It increments when `v_rd`=1 and `relu_in[SUM_WIDTH-1]`=1.
  - It holds after `done` until the next `start`.
- Not defined: port and counter are absent; the rest of the behaviour is identical.

## Structure
- Package `relu_seq_pkg`:
  - state enum `relu_seq_state_t`
  - default `SUM_WIDTH`/`NUM_DATA` localparams
  - helper function for length clamping
- One sub-module: `relu_seq_addr_cnt`, a clear/enable address counter with terminal-count flag. It is instantiated twice, once for read and once for write.
- The RELU itself is instantiated outside, at the layer level, not inside this block.

## Test plan
- `len`=128, input RAM preloaded with 128 hex words:
  - writes at addresses 0…127
  - each written word is the input if its sign bit is 0, else 0x00000000
  - `done` at start+131
- `len`=0 → `done` on the next cycle; zero `rd_en`/`wr_en` pulses; `busy` stays 0.
- `len`=200 → clamped to 128; last `wr_addr`=127; `done` at start+131.
- `start` pulsed again at start+5 during a `len`=10 pass → ignored; exactly 10 writes; one `done`.
- `rst_n` dropped at start+4 of a `len`=20 pass:
  - all outputs reach reset values immediately
  - a new `start` after reset release runs a full 20-word pass
- With `RELU_SEQ_STATS_EN`, `len`=4 over inputs 0x00000005, 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF:
  - writes are 5, 0, 0, 0x7FFFFFFF
  - `neg_count`=2

Source files
------------

// File: rtl/relu_seq_pkg.sv
// Shared types and defaults for the ReLU stage sequencer.
// Optional feature macro: RELU_SEQ_STATS_EN (adds the neg_count statistics port).
package relu_seq_pkg;

    localparam int unsigned DEF_SUM_WIDTH = 32;
    localparam int unsigned DEF_NUM_DATA  = 128;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } relu_seq_state_t;

    // Requested pass length limited to the buffer depth
    function automatic int unsigned clamp_len(input int unsigned req_len,
                                              input int unsigned max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/relu_seq_addr_cnt.sv
// Clear/enable buffer address counter with a terminal-count flag.
// The count parks on the terminal value instead of wrapping past it.
module relu_seq_addr_cnt #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    // Next count: clear wins, otherwise step until the terminal address
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/relu_seq_ctrl.sv
// Sequencer that streams a block of words from the input activation buffer
// through the external registered ReLU stage into the output buffer.
// Optional feature macro: RELU_SEQ_STATS_EN (counts inputs clamped to zero).
//
// Control handshake: start is a request that is accepted only in the cycle
// the sequencer is idle (busy=0, done=0); len is captured in that same cycle.
// done is a single-cycle completion pulse; the next start is accepted from
// the cycle after done. There is no backpressure on either buffer.
module relu_seq_ctrl
    import relu_seq_pkg::*;
#(
    parameter int unsigned SUM_WIDTH  = DEF_SUM_WIDTH,
    parameter int unsigned NUM_DATA   = DEF_NUM_DATA,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_DATA)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SUM_WIDTH-1:0]  rd_data,
    output logic [SUM_WIDTH-1:0]  relu_in,
    input  logic [SUM_WIDTH-1:0]  relu_out,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [SUM_WIDTH-1:0]  wr_data,
    output relu_seq_state_t       dbg_state
`ifdef RELU_SEQ_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   neg_count
`endif
);

    relu_seq_state_t       state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_en_q;
    logic                  v_rd_q;
    logic                  v_relu_q;
    logic [ADDR_WIDTH-1:0] last_q;

    logic [ADDR_WIDTH:0]   eff_len_w;
    logic                  start_acc_w;
    logic                  rd_tc_w;
    logic                  wr_tc_w;
    logic [ADDR_WIDTH-1:0] rd_cnt_w;
    logic [ADDR_WIDTH-1:0] wr_cnt_w;

    assign eff_len_w   = (ADDR_WIDTH+1)'(clamp_len(32'(len), NUM_DATA));
    assign start_acc_w = (state_q == ST_IDLE) && start;

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_cnt_w;
    assign relu_in   = rd_data;
    assign wr_en     = v_relu_q;
    assign wr_addr   = wr_cnt_w;
    assign wr_data   = relu_out;
    assign dbg_state = state_q;

    // Read address: steps once per issued read
    relu_seq_addr_cnt #(
        .WIDTH (ADDR_WIDTH)
    ) u_rd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc_w),
        .en_i   (rd_en_q),
        .last_i (last_q),
        .cnt_o  (rd_cnt_w),
        .tc_o   (rd_tc_w)
    );

    // Write address: steps once per issued write
    relu_seq_addr_cnt #(
        .WIDTH (ADDR_WIDTH)
    ) u_wr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc_w),
        .en_i   (v_relu_q),
        .last_i (last_q),
        .cnt_o  (wr_cnt_w),
        .tc_o   (wr_tc_w)
    );

    // Control FSM with registered busy/done/read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            last_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // eff_len=NUM_DATA truncates to 0, so the subtraction yields NUM_DATA-1
                        last_q <= eff_len_w[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                        if (eff_len_w == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_tc_w) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (v_relu_q && wr_tc_w) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage valid pipeline following the RAM read and the ReLU register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_rd_q   <= 1'b0;
            v_relu_q <= 1'b0;
        end else begin
            v_rd_q   <= rd_en_q;
            v_relu_q <= v_rd_q;
        end
    end

`ifdef RELU_SEQ_STATS_EN
    logic [ADDR_WIDTH:0] neg_count_q;

    assign neg_count = neg_count_q;

    // Count valid inputs whose sign bit makes the ReLU clamp them to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_count_q <= '0;
        end else if (start_acc_w) begin
            neg_count_q <= '0;
        end else if (v_rd_q && rd_data[SUM_WIDTH-1]) begin
            neg_count_q <= neg_count_q + (ADDR_WIDTH+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Self-checking bench for relu_seq_ctrl with behavioural RAM and ReLU models.
// Optional feature macro: RELU_SEQ_STATS_EN (enables the neg_count checks).
module tb_relu_seq_ctrl;
    import relu_seq_pkg::*;

    localparam int SW = 32;
    localparam int ND = 128;
    localparam int AW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [SW-1:0] rd_data = '0;
    logic [SW-1:0] relu_in, wr_data;
    logic [SW-1:0] relu_out = '0;
    relu_seq_state_t dbg_state;
`ifdef RELU_SEQ_STATS_EN
    logic [AW:0]   neg_count;
`endif

    relu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .relu_in   (relu_in),
        .relu_out  (relu_out),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_state (dbg_state)
`ifdef RELU_SEQ_STATS_EN
        ,
        .neg_count (neg_count)
`endif
    );

    // ---------------- environment models ----------------
    logic [SW-1:0] in_mem [ND];

    function automatic logic [SW-1:0] relu_ref(input logic [SW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= in_mem[rd_addr];
    always @(posedge clk) relu_out <= relu_ref(relu_in);

    // ---------------- monitor ----------------
    int            rd_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [SW-1:0] wr_data_q[$];
    int            busy_cyc_q[$];
    int            done_cyc_q[$];

    always @(negedge clk) begin
        if (rd_en) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(rd_addr); end
        if (wr_en) begin
            wr_cyc_q.push_back(cyc); wr_addr_q.push_back(wr_addr); wr_data_q.push_back(wr_data);
        end
        if (busy) busy_cyc_q.push_back(cyc);
        if (done) done_cyc_q.push_back(cyc);
    end

    // ---------------- scoreboard state ----------------
    logic [SW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int start_cyc = 0;
    int exp_len = 0;
    int exp_neg = 0;

    task automatic clear_mon();
        rd_cyc_q.delete(); rd_addr_q.delete();
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        busy_cyc_q.delete(); done_cyc_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int i = 0; i < ND; i++) in_mem[i] = $urandom;
    endtask

    task automatic start_pass(input int l);
        int eff;
        @(negedge clk);
        clear_mon();
        exp_q.delete();
        eff = (l > ND) ? ND : l;
        exp_len = eff;
        exp_neg = 0;
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back(relu_ref(in_mem[i]));
            if ($signed(in_mem[i]) < 0) exp_neg++;
        end
        len = (AW+1)'(l);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        len = (AW+1)'($urandom);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cyc_q.size() == 0 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (done_cyc_q.size() == 0) begin
            failures++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000 || rd_addr !== '0 || wr_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d required all 0",
                     busy, done, rd_en, wr_en, rd_addr, wr_addr);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
`ifdef RELU_SEQ_STATS_EN
        checks++;
        if (neg_count !== '0) begin
            failures++; $display("FAIL reset_neg_count: got %0d required 0", neg_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b rd_en=%b wr_en=%b required 0", busy, done, rd_en, wr_en);
        end
    endtask

    task automatic test_full_len(input int l, input string name);
        fill_random();
        start_pass(l);
        wait_done(ND + 20, name);
        checks++;
        if (wr_addr_q.size() != exp_len) begin
            failures++; $display("FAIL %s_wr_count: got %0d required %0d", name, wr_addr_q.size(), exp_len);
        end
        for (int i = 0; i < wr_addr_q.size() && i < exp_len; i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i] || wr_cyc_q[i] != start_cyc + 3 + i) begin
                failures++;
                $display("FAIL %s_write[%0d]: addr=%0d data=%h cyc=+%0d required addr=%0d data=%h cyc=+%0d",
                         name, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - start_cyc, i, exp_q[i], 3 + i);
            end
        end
        checks++;
        if (rd_addr_q.size() != exp_len) begin
            failures++; $display("FAIL %s_rd_count: got %0d required %0d", name, rd_addr_q.size(), exp_len);
        end
        for (int i = 0; i < rd_addr_q.size() && i < exp_len; i++) begin
            checks++;
            if (rd_addr_q[i] !== AW'(i) || rd_cyc_q[i] != start_cyc + 1 + i) begin
                failures++;
                $display("FAIL %s_read[%0d]: addr=%0d cyc=+%0d required addr=%0d cyc=+%0d",
                         name, i, rd_addr_q[i], rd_cyc_q[i] - start_cyc, i, 1 + i);
            end
        end
        checks++;
        if (busy_cyc_q.size() != exp_len + 2 || (busy_cyc_q.size() > 0 && busy_cyc_q[0] != start_cyc + 1)) begin
            failures++;
            $display("FAIL %s_busy: cycles=%0d first=+%0d required cycles=%0d first=+1",
                     name, busy_cyc_q.size(), (busy_cyc_q.size() > 0) ? busy_cyc_q[0] - start_cyc : -1, exp_len + 2);
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + exp_len + 3) begin
            failures++;
            $display("FAIL %s_done_cycle: count=%0d at=+%0d required count=1 at=+%0d",
                     name, done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, exp_len + 3);
        end
`ifdef RELU_SEQ_STATS_EN
        checks++;
        if (neg_count !== (AW+1)'(exp_neg)) begin
            failures++; $display("FAIL %s_neg_count: got %0d required %0d", name, neg_count, exp_neg);
        end
`endif
    endtask

    task automatic test_len_zero();
        start_pass(0);
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + 1) begin
            failures++;
            $display("FAIL len0_done: count=%0d at=+%0d required count=1 at=+1",
                     done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1);
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (rd_cyc_q.size() != 0 || wr_cyc_q.size() != 0 || busy_cyc_q.size() != 0 || done_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL len0_activity: rd=%0d wr=%0d busy=%0d done=%0d required 0 0 0 1",
                     rd_cyc_q.size(), wr_cyc_q.size(), busy_cyc_q.size(), done_cyc_q.size());
        end
    endtask

    task automatic test_clamp();
        fill_random();
        start_pass(200);
        wait_done(ND + 20, "clamp");
        checks++;
        if (wr_addr_q.size() != ND || wr_addr_q[wr_addr_q.size() - 1] !== AW'(ND - 1)) begin
            failures++;
            $display("FAIL clamp_writes: count=%0d last_addr=%0d required count=%0d last_addr=%0d",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? int'(wr_addr_q[wr_addr_q.size() - 1]) : -1, ND, ND - 1);
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + ND + 3) begin
            failures++;
            $display("FAIL clamp_done: at=+%0d required +%0d",
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, ND + 3);
        end
        for (int i = 0; i < wr_data_q.size() && i < exp_len; i++) begin
            checks++;
            if (wr_data_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL clamp_data[%0d]: got %h required %h", i, wr_data_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        start_pass(10);
        repeat (4) @(negedge clk);
        start = 1'b1;
        len = (AW+1)'(3);
        @(negedge clk);
        start = 1'b0;
        wait_done(40, "restart");
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() != 10 || done_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL restart_counts: writes=%0d dones=%0d required 10 1", wr_addr_q.size(), done_cyc_q.size());
        end
        checks++;
        if (done_cyc_q.size() > 0 && done_cyc_q[0] != start_cyc + 13) begin
            failures++; $display("FAIL restart_done: at=+%0d required +13", done_cyc_q[0] - start_cyc);
        end
        for (int i = 0; i < wr_data_q.size() && i < exp_len; i++) begin
            checks++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL restart_write[%0d]: addr=%0d data=%h required addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        fill_random();
        start_pass(20);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000 || rd_addr !== '0 || wr_addr !== '0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d required all 0",
                     busy, done, rd_en, wr_en, rd_addr, wr_addr);
        end
        clear_mon();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (rd_cyc_q.size() != 0 || wr_cyc_q.size() != 0 || done_cyc_q.size() != 0 || busy_cyc_q.size() != 0) begin
            failures++;
            $display("FAIL abort_activity: rd=%0d wr=%0d done=%0d busy=%0d required 0",
                     rd_cyc_q.size(), wr_cyc_q.size(), done_cyc_q.size(), busy_cyc_q.size());
        end
        test_full_len(20, "after_abort");
    endtask

    task automatic test_back_to_back();
        int l2;
        fill_random();
        start_pass(7);
        wait_done(40, "b2b_first");
        l2 = $urandom_range(1, 12);
        start_pass(l2);
        wait_done(40, "b2b_second");
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + l2 + 3 || wr_addr_q.size() != l2) begin
            failures++;
            $display("FAIL b2b_second: done_at=+%0d writes=%0d required done_at=+%0d writes=%0d",
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, wr_addr_q.size(), l2 + 3, l2);
        end
        for (int i = 0; i < wr_data_q.size() && i < exp_len; i++) begin
            checks++;
            if (wr_data_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wr_data_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef RELU_SEQ_STATS_EN
    task automatic test_stats();
        logic [SW-1:0] want [4];
        in_mem[0] = 32'h0000_0005; in_mem[1] = 32'hFFFF_FFFF;
        in_mem[2] = 32'h8000_0000; in_mem[3] = 32'h7FFF_FFFF;
        want[0] = 32'h0000_0005; want[1] = 32'h0;
        want[2] = 32'h0;         want[3] = 32'h7FFF_FFFF;
        start_pass(4);
        wait_done(20, "stats");
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== want[i]) begin
                failures++; $display("FAIL stats_data[%0d]: got %h required %h", i, wr_data_q[i], want[i]);
            end
        end
        checks++;
        if (neg_count !== (AW+1)'(2)) begin
            failures++; $display("FAIL stats_neg_count: got %0d required 2", neg_count);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (neg_count !== (AW+1)'(2)) begin
            failures++; $display("FAIL stats_hold: got %0d required 2", neg_count);
        end
    endtask
`endif

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_full_len(128, "full");
        test_len_zero();
        test_clamp();
        test_start_ignored();
        test_reset_mid_pass();
        test_back_to_back();
        test_full_len(1, "len1");
        for (int k = 0; k < 5; k++) test_full_len($urandom_range(2, 40), "rand");
`ifdef RELU_SEQ_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
